// File: rtl/multi_channel_memory.sv
// -----------------------------------------------------------------------------
// multi_channel_memory
//
// Single-write-port memory shared by NUM_CH read channels. The read channels
// reach the storage through one read port, handed out by a registered
// round-robin arbiter. A write in a cycle blocks every read in that cycle.
// Out-of-range accesses are flagged rather than aliased onto valid words.
//
// Ports
//   Clock, Reset_n    : rising-edge clock, asynchronous active-low reset
//   iWriteEnable      : write request this cycle
//   iAddress          : write address
//   iDataIn           : write data
//   iReadReq          : per-channel read request (bit k = channel k)
//   iReadAddress      : channel k address at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   oDataOut          : channel k data at [k*DATA_WIDTH +: DATA_WIDTH], held
//   oDataValid        : one-cycle pulse, channel k read completed
//   oError            : one-cycle pulse with oDataValid[k], address out of range
//   oWriteError       : one-cycle pulse, write address out of range (dropped)
// -----------------------------------------------------------------------------
module multi_channel_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_SIZE   = 1024,
  parameter int NUM_CH     = 2
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  input  logic                         iWriteEnable,
  input  logic [ADDR_WIDTH-1:0]        iAddress,
  input  logic [DATA_WIDTH-1:0]        iDataIn,
  input  logic [NUM_CH-1:0]            iReadReq,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] iReadAddress,
  output logic [NUM_CH*DATA_WIDTH-1:0] oDataOut,
  output logic [NUM_CH-1:0]            oDataValid,
  output logic [NUM_CH-1:0]            oError,
  output logic                         oWriteError
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  // One extra bit so MEM_SIZE == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]  MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [PTR_W-1:0]     LAST_CH   = PTR_W'(NUM_CH - 1);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < MEM_LIMIT;
  endfunction

  function automatic logic [PTR_W-1:0] next_ch(input logic [PTR_W-1:0] ch);
    return (ch == LAST_CH) ? '0 : ch + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic                  write_ok;

  assign write_ok = iWriteEnable && in_range(iAddress);

  // NOTE: the storage array has no reset branch; clearing every word would
  // force flops instead of a RAM, and its contents are undefined after reset.
  always_ff @(posedge Clock) begin
    if (write_ok) begin
      mem[iAddress[IDX_W-1:0]] <= iDataIn;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel read addresses
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] rd_addr [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_addr
    assign rd_addr[k] = iReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: search starts at rr_ptr_q and wraps. A write in the
  // same cycle suppresses every grant, so pending requests simply wait.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             grant_vld;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] search_idx;

  // NOTE: every signal assigned in an always_comb gets a default value first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    search_idx = rr_ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_vld && iReadReq[search_idx]) begin
        grant_vld = 1'b1;
        grant_idx = search_idx;
      end
      search_idx = next_ch(search_idx);
    end
    if (iWriteEnable) begin
      grant_vld = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output / state next-value logic
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_out_q [NUM_CH];
  logic [DATA_WIDTH-1:0] data_out_d [NUM_CH];
  logic [NUM_CH-1:0]     data_valid_q, data_valid_d;
  logic [NUM_CH-1:0]     error_q, error_d;
  logic                  write_error_q, write_error_d;
  logic [ADDR_WIDTH-1:0] sel_addr;

  assign sel_addr = rd_addr[grant_idx];

  always_comb begin
    data_out_d    = data_out_q;   // non-granted channels hold their word
    data_valid_d  = '0;
    error_d       = '0;
    write_error_d = iWriteEnable && !in_range(iAddress);
    rr_ptr_d      = rr_ptr_q;
    if (grant_vld) begin
      data_valid_d[grant_idx] = 1'b1;
      rr_ptr_d                = next_ch(grant_idx);
      if (in_range(sel_addr)) begin
        data_out_d[grant_idx] = mem[sel_addr[IDX_W-1:0]];
      end else begin
        data_out_d[grant_idx] = '0;
        error_d[grant_idx]    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        data_out_q[k] <= '0;
      end
      data_valid_q  <= '0;
      error_q       <= '0;
      write_error_q <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      error_q       <= error_d;
      write_error_q <= write_error_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign oDataOut[k*DATA_WIDTH +: DATA_WIDTH] = data_out_q[k];
  end

  assign oDataValid  = data_valid_q;
  assign oError      = error_q;
  assign oWriteError = write_error_q;

endmodule

// File: tb/tb_multi_channel_memory.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_memory
//
// Directed bench for multi_channel_memory. Two instances share clock and
// reset: a 2-channel, 10-word instance and a 4-channel, 16-word instance.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same
// point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_multi_channel_memory;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2-channel instance, MEM_SIZE = 10
  logic        we2 = 1'b0;
  logic [9:0]  addr2 = '0;
  logic [7:0]  din2 = '0;
  logic [1:0]  req2 = '0;
  logic [19:0] raddr2 = '0;
  logic [15:0] dout2;
  logic [1:0]  dv2, err2;
  logic        werr2;

  // 4-channel instance, MEM_SIZE = 16
  logic        we4 = 1'b0;
  logic [3:0]  addr4 = '0;
  logic [7:0]  din4 = '0;
  logic [3:0]  req4 = '0;
  logic [15:0] raddr4 = '0;
  logic [31:0] dout4;
  logic [3:0]  dv4, err4;
  logic        werr4;

  multi_channel_memory #(
    .DATA_WIDTH(8), .ADDR_WIDTH(10), .MEM_SIZE(10), .NUM_CH(2)
  ) u_dut2 (
    .Clock(clk), .Reset_n(rst_n),
    .iWriteEnable(we2), .iAddress(addr2), .iDataIn(din2),
    .iReadReq(req2), .iReadAddress(raddr2),
    .oDataOut(dout2), .oDataValid(dv2), .oError(err2), .oWriteError(werr2)
  );

  multi_channel_memory #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .MEM_SIZE(16), .NUM_CH(4)
  ) u_dut4 (
    .Clock(clk), .Reset_n(rst_n),
    .iWriteEnable(we4), .iAddress(addr4), .iDataIn(din4),
    .iReadReq(req4), .iReadAddress(raddr4),
    .oDataOut(dout4), .oDataValid(dv4), .oError(err4), .oWriteError(werr4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expected contents of the 10-word memory.
  logic [7:0] exp2 [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({dout2, dv2, err2, werr2} !== 21'd0) $display("FAIL reset_dut2: got %h want 0", {dout2, dv2, err2, werr2});
    else n_pass++;
    n_checks++;
    if ({dout4, dv4, err4, werr4} !== 41'd0) $display("FAIL reset_dut4: got %h want 0", {dout4, dv4, err4, werr4});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Preload both memories.
    for (int i = 0; i < 10; i++) begin
      exp2[i] = 8'h30 + 8'(i);
    end
    exp2[1] = 8'h11;
    exp2[2] = 8'h22;
    we2 = 1'b1;
    we4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr2 = 10'(i);
      din2  = exp2[i];
      addr4 = 4'(i);
      din4  = 8'hC0 + 8'(i);
      tick();
    end
    we2 = 1'b0;
    we4 = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_read();
    we2 = 1'b1; addr2 = 10'd3; din2 = 8'hA5;
    exp2[3] = 8'hA5;
    tick();
    we2 = 1'b0;
    req2 = 2'b01; raddr2[9:0] = 10'd3;
    tick();
    req2 = 2'b00;
    n_checks++;
    if (dv2 !== 2'b01) $display("FAIL single_valid: got %b want 01", dv2);
    else n_pass++;
    n_checks++;
    if (dout2[7:0] !== 8'hA5) $display("FAIL single_data: got %h want a5", dout2[7:0]);
    else n_pass++;

    // Asynchronous reset mid-run: outputs clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout2, dv2, err2} !== 20'd0) $display("FAIL async_reset: got %h want 0", {dout2, dv2, err2});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (dv2 !== 2'b00) $display("FAIL after_reset_valid: got %b want 00", dv2);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    req2 = 2'b11; raddr2 = {10'd2, 10'd1};
    tick();
    n_checks++;
    if ({dv2, dout2} !== {2'b01, 8'h00, 8'h11}) $display("FAIL rr_grant0: got %b/%h want 01/0011", dv2, dout2);
    else n_pass++;
    tick();
    n_checks++;
    if ({dv2, dout2} !== {2'b10, 8'h22, 8'h11}) $display("FAIL rr_grant1: got %b/%h want 10/2211", dv2, dout2);
    else n_pass++;
    tick();
    n_checks++;
    if ({dv2, dout2} !== {2'b01, 8'h22, 8'h11}) $display("FAIL rr_grant2: got %b/%h want 01/2211", dv2, dout2);
    else n_pass++;
    req2 = 2'b00;
    tick();
    n_checks++;
    if (dv2 !== 2'b00) $display("FAIL rr_idle: got %b want 00", dv2);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write_priority();
    we2 = 1'b1; addr2 = 10'd7; din2 = 8'h77;
    exp2[7] = 8'h77;
    req2 = 2'b10; raddr2[19:10] = 10'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dv2 !== 2'b00) $display("FAIL wp_blocked_%0d: got %b want 00", i, dv2);
      else n_pass++;
    end
    we2 = 1'b0;
    tick();
    req2 = 2'b00;
    n_checks++;
    if ({dv2, dout2[15:8]} !== {2'b10, exp2[5]}) $display("FAIL wp_served: got %b/%h want 10/%h", dv2, dout2[15:8], exp2[5]);
    else n_pass++;

    // Write followed immediately by a read of the same word.
    we2 = 1'b1; addr2 = 10'd8; din2 = 8'h88;
    exp2[8] = 8'h88;
    tick();
    we2 = 1'b0;
    req2 = 2'b01; raddr2[9:0] = 10'd8;
    tick();
    req2 = 2'b00;
    n_checks++;
    if ({dv2, dout2[7:0]} !== {2'b01, 8'h88}) $display("FAIL write_then_read: got %b/%h want 01/88", dv2, dout2[7:0]);
    else n_pass++;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_out_of_range();
    we2 = 1'b1; addr2 = 10'd12; din2 = 8'hFF;
    tick();
    we2 = 1'b0;
    n_checks++;
    if (werr2 !== 1'b1) $display("FAIL werr_pulse: got %b want 1", werr2);
    else n_pass++;
    tick();
    n_checks++;
    if (werr2 !== 1'b0) $display("FAIL werr_clear: got %b want 0", werr2);
    else n_pass++;

    // Every in-range word must be untouched by the dropped write.
    req2 = 2'b01;
    for (int i = 0; i < 10; i++) begin
      raddr2[9:0] = 10'(i);
      tick();
      n_checks++;
      if ({dv2, err2, dout2[7:0]} !== {2'b01, 2'b00, exp2[i]})
        $display("FAIL mem_word_%0d: got %b/%b/%h want 01/00/%h", i, dv2, err2, dout2[7:0], exp2[i]);
      else n_pass++;
    end

    // Out-of-range read on channel 1.
    req2 = 2'b10; raddr2[19:10] = 10'd10;
    tick();
    req2 = 2'b00;
    n_checks++;
    if ({dv2, err2, dout2} !== {2'b10, 2'b10, 8'h00, exp2[9]})
      $display("FAIL oor_read: got %b/%b/%h want 10/10/00%h", dv2, err2, dout2, exp2[9]);
    else n_pass++;
    tick();
    n_checks++;
    if ({dv2, err2} !== 4'b0000) $display("FAIL oor_clear: got %b/%b want 00/00", dv2, err2);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_read();
    // Grant ch0 so the pointer moves to 1.
    req2 = 2'b01; raddr2 = {10'd2, 10'd3};
    tick();
    n_checks++;
    if ({dv2, dout2[7:0]} !== {2'b01, 8'hA5}) $display("FAIL rmr_first: got %b/%h want 01/a5", dv2, dout2[7:0]);
    else n_pass++;
    // Both channels now pending; reset lands before the next edge.
    req2 = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dv2, dout2} !== 18'd0) $display("FAIL rmr_async: got %b/%h want 00/0000", dv2, dout2);
    else n_pass++;
    tick();
    n_checks++;
    if (dv2 !== 2'b00) $display("FAIL rmr_no_valid: got %b want 00", dv2);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // Pointer restarts at 0, so ch0 wins over ch1.
    req2 = 2'b00;
    n_checks++;
    if ({dv2, dout2[7:0]} !== {2'b01, 8'hA5}) $display("FAIL rmr_rearb: got %b/%h want 01/a5", dv2, dout2[7:0]);
    else n_pass++;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_scaling();
    int order_all  [4] = '{0, 1, 2, 3};
    int order_drop [4] = '{0, 1, 3, 0};
    int ch;
    logic [3:0] want_v;
    logic [7:0] want_d;
    req4 = 4'b1111; raddr4 = {4'd3, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 4; i++) begin
      ch = order_all[i];
      want_v = 4'b0001 << ch;
      want_d = 8'hC0 + 8'(ch);
      tick();
      n_checks++;
      if ({dv4, dout4[ch*8 +: 8]} !== {want_v, want_d})
        $display("FAIL scale_all_%0d: got %b/%h want %b/%h", i, dv4, dout4[ch*8 +: 8], want_v, want_d);
      else n_pass++;
    end
    req4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      ch = order_drop[i];
      want_v = 4'b0001 << ch;
      want_d = 8'hC0 + 8'(ch);
      tick();
      n_checks++;
      if ({dv4, dout4[ch*8 +: 8]} !== {want_v, want_d})
        $display("FAIL scale_drop_%0d: got %b/%h want %b/%h", i, dv4, dout4[ch*8 +: 8], want_v, want_d);
      else n_pass++;
    end
    req4 = 4'b0000;
    tick();
    n_checks++;
    if (dv4 !== 4'b0000) $display("FAIL scale_idle: got %b want 0000", dv4);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_priority();
    test_out_of_range();
    test_reset_mid_read();
    test_scaling();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_channel_memory.md
# multi_channel_memory

Single-write-port, multi-read-channel synchronous memory generalising the two-output (a/b) memory to NUM_CH read channels. Read channels share one read port through a registered round-robin arbiter with a req/valid handshake. Writes take priority over reads. Out-of-range accesses are flagged instead of silently aliasing. It sits between the data producer (write side) and the processing units that consume stored words (read channels).

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 10, address width in bits
- MEM_SIZE, 1024, number of words; valid addresses 0..MEM_SIZE-1; must be ≤ 2^ADDR_WIDTH
- NUM_CH, 2, number of read channels; ≥ 1
- Clock  in  1  single clock; all state updates on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- iWriteEnable  in  1  write request this cycle
- iAddress  in  ADDR_WIDTH  write address
- iDataIn  in  DATA_WIDTH  write data
- iReadReq  in  NUM_CH  per-channel read request; bit k is channel k
- iReadAddress  in  NUM_CH*ADDR_WIDTH  channel k address in bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- oDataOut  out  NUM_CH*DATA_WIDTH  channel k data in bits [k*DATA_WIDTH +: DATA_WIDTH]; holds its last value
- oDataValid  out  NUM_CH  one-cycle pulse: channel k read completed, slice k updated
- oError  out  NUM_CH  one-cycle pulse alongside oDataValid[k] when the read address was out of range
- oWriteError  out  1  one-cycle pulse: the write address was out of range; the write was dropped

## Operation
- Storage array is MEM_SIZE words. Contents are not reset.
- Write: iWriteEnable=1 with iAddress<MEM_SIZE writes iDataIn at the edge.
- Write: iAddress≥MEM_SIZE drops the write and pulses oWriteError on the next cycle.
- Write priority: in any cycle with iWriteEnable=1, no read is granted. Pending requests wait. Starvation under continuous writes is by design.
- Arbitration: in a cycle with iWriteEnable=0 and any iReadReq set, exactly one channel is granted, chosen round-robin.
- Priority search starts at the pointer rr_ptr and wraps modulo NUM_CH. After granting channel k, rr_ptr becomes (k+1) mod NUM_CH. With no grant, rr_ptr is unchanged.
- Granted read, in range: oDataOut slice k ← Memory[addr] and oDataValid[k]=1, both on the next cycle.
- Granted read, addr≥MEM_SIZE: slice k ← 0, oDataValid[k]=1 and oError[k]=1.
- Handshake: the requester holds iReadReq[k] and its address stable until it sees oDataValid[k]. Deasserting early withdraws the request with no side effects.
- Reissue: a requester that keeps iReadReq[k] high in the cycle oDataValid[k] is seen issues a new request.
- Non-granted channels keep their oDataOut slices unchanged.

## Timing
- Read latency: 1 cycle from the granting edge. The request sampled at edge T gives data/valid after edge T, visible in cycle T+1.
- Back-to-back: one grant per cycle at most. N channels requesting continuously are each served once every N cycles.
- Same-cycle read/write to the same address cannot occur, because writes block reads.
- Write-then-read: a read granted the cycle after a write to the same address returns the new data.
- Reset (Reset_n=0, asynchronous):
  - oDataOut=0, oDataValid=0, oError=0, oWriteError=0, rr_ptr=0.
  - Reset during a pending or granted read cancels it; no valid pulse is produced for it.
  - After release, held requests are re-arbitrated from rr_ptr=0.
- Outputs are registered only. There are no combinational paths from inputs to outputs.

## Test plan
- Reset and single read:
  - Assert Reset_n=0 mid-run: all outputs go 0 immediately.
  - Release, write 0xA5 at address 3, then request channel 0 at address 3: oDataValid=01 one cycle later and slice 0 = 0xA5.
- Round-robin: NUM_CH=2, both channels held requesting addresses 1/2 (holding 0x11/0x22). Grants alternate ch0, ch1, ch0; each valid pulse carries the correct word; slice 1 is unchanged on ch0 cycles.
- Write priority: iWriteEnable=1 for 3 cycles while ch1 requests. No oDataValid during those cycles; ch1 is served in the cycle after writes stop.
- Out of range, MEM_SIZE=10:
  - Write to address 12: oWriteError pulses and addresses 0..9 are unchanged.
  - Read at address 10: slice = 0, oDataValid and oError pulse together.
- Reset mid-read: pull Reset_n low in the cycle after a grant. No valid pulse appears. After release, the held request completes with the correct data and rr_ptr starts from 0.
- Scaling: NUM_CH=4 with all channels requesting. Service order is 0,1,2,3,0. After ch2 drops its request, the order becomes 0,1,3,0.
